// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadows the EX/MEM
// producers, registers the EX-stage ALU forward selects, and raises load-use stalls.
module hazard_forward_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_write_reg,
  output logic [1:0]        forward_EXE_A,
  output logic [1:0]        forward_EXE_B,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } prod_t;

  // The WB data select is resolved one cycle early against the MEM slot, so
  // the instruction retiring from MEM never needs to be tracked further.
  prod_t             ex_q, ex_d;
  prod_t             mem_q, mem_d;
  logic              ex_load_q, ex_load_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;
  logic              bubble;

  function automatic logic hits(input prod_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_write & (s.dst == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input prod_t ex_s, input prod_t mem_s,
                                         input logic use_r, input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && hits(ex_s, r)) begin
      sel = 2'b01;
    end else if (use_r && hits(mem_s, r)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = id_valid & ~flush & ex_load_q & hits(ex_q, ex_q.dst) &
               ((id_use_rs & (ex_q.dst == id_rs)) | (id_use_rt & (ex_q.dst == id_rt)));
    bubble   = load_use | flush | ~id_valid;
  end

  always_comb begin
    ex_d      = ex_q;
    ex_load_d = ex_load_q;
    mem_d     = mem_q;
    fwd_a_d   = fwd_a_q;
    fwd_b_d   = fwd_b_q;
    cnt_d     = cnt_q;
    if (en) begin
      mem_d = ex_q;
      if (bubble) begin
        ex_d      = '0;
        ex_load_d = 1'b0;
        fwd_a_d   = 2'b00;
        fwd_b_d   = 2'b00;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.reg_write = id_reg_write;
        ex_d.dst       = id_write_reg;
        ex_load_d      = id_mem_read;
        fwd_a_d        = fwd_sel(ex_q, mem_q, id_use_rs, id_rs);
        fwd_b_d        = fwd_sel(ex_q, mem_q, id_use_rt, id_rt);
      end
      if (load_use && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      ex_load_q <= 1'b0;
      mem_q     <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      ex_load_q <= ex_load_d;
      mem_q     <= mem_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign forward_EXE_A = fwd_a_q;
  assign forward_EXE_B = fwd_b_q;
  assign stall         = load_use;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: an in-order issue-history model checks
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_hazard_forward_unit;

  localparam int CNT_W  = 4;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, en, flush, id_valid;
  logic [4:0]       id_rs, id_rt, id_write_reg;
  logic             id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [1:0]       forward_EXE_A, forward_EXE_B;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_write_reg(id_write_reg),
    .forward_EXE_A(forward_EXE_A), .forward_EXE_B(forward_EXE_B),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: history of what entered EX on each advancing edge (newest last).
  typedef struct {
    bit       v;
    bit       rw;
    bit       ld;
    bit [4:0] d;
  } ent_t;

  ent_t hist[$];
  int   m_fa, m_fb, m_stalls;

  function automatic ent_t slot_at(int age);
    ent_t b;
    b = '{v: 1'b0, rw: 1'b0, ld: 1'b0, d: 5'd0};
    if (hist.size() > age) b = hist[hist.size() - 1 - age];
    return b;
  endfunction

  function automatic bit writes(ent_t e, bit [4:0] r);
    return e.v && e.rw && e.d == r && r != 0;
  endfunction

  function automatic int sel_for(bit use_r, bit [4:0] r);
    if (!use_r) return 0;
    if (writes(slot_at(0), r)) return 1;
    if (writes(slot_at(1), r)) return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    ent_t e;
    e = slot_at(0);
    if (!id_valid || flush || !e.ld) return 1'b0;
    return (id_use_rs && writes(e, id_rs)) || (id_use_rt && writes(e, id_rt));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_fa = 0; m_fb = 0; m_stalls = 0;
    end else if (en) begin
      bit s;
      ent_t n;
      s = m_stall();
      if (s) m_stalls++;
      if (s || flush || !id_valid) begin
        n = '{v: 1'b0, rw: 1'b0, ld: 1'b0, d: 5'd0};
        m_fa = 0; m_fb = 0;
      end else begin
        n = '{v: 1'b1, rw: id_reg_write, ld: id_mem_read, d: id_write_reg};
        m_fa = sel_for(id_use_rs, id_rs);
        m_fb = sel_for(id_use_rt, id_rt);
      end
      hist.push_back(n);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("model_stall", stall, m_stall());
    chk("model_fwd_a", forward_EXE_A, m_fa);
    chk("model_fwd_b", forward_EXE_B, m_fb);
    chk("model_cnt", stall_cnt, (m_stalls > CNTMAX) ? CNTMAX : m_stalls);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit rw, input bit ld, input bit [4:0] wr);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_reg_write = rw; id_mem_read = ld; id_write_reg = wr;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_write_reg = '0;
  endtask

  task automatic drain();
    nop(); tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; flush = 1'b0;
    nop();
    tick(); tick();
    #1;
    chk("reset_stall", stall, 0);
    chk("reset_fwd_a", forward_EXE_A, 0);
    chk("reset_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    instr(1, 2, 1, 1, 1, 0, 3); tick();
    instr(3, 5, 1, 1, 1, 0, 4); tick(); #1;
    chk("exmem_fwd_a", forward_EXE_A, 1);
    chk("exmem_fwd_b", forward_EXE_B, 0);
    drain();

    // add $3 ; nop ; or $6,$7,$3
    instr(1, 2, 1, 1, 1, 0, 3); tick();
    nop(); tick();
    instr(7, 3, 1, 1, 1, 0, 6); tick(); #1;
    chk("wb_fwd_a", forward_EXE_A, 0);
    chk("wb_fwd_b", forward_EXE_B, 2);
    drain();

    // lw $8,0($1) ; add $9,$8,$8
    instr(1, 0, 1, 0, 1, 1, 8); tick();
    instr(8, 8, 1, 1, 1, 0, 9); #1;
    chk("lu_stall_hi", stall, 1);
    tick(); #1;
    chk("lu_stall_lo", stall, 0);
    chk("lu_bubble_a", forward_EXE_A, 0);
    tick(); #1;
    chk("lu_fwd_a", forward_EXE_A, 2);
    chk("lu_fwd_b", forward_EXE_B, 2);
    chk("lu_cnt", stall_cnt, 1);
    drain();

    // two writers of $3, then sub $4,$3,$3 ; then $0 writer and reader
    instr(1, 2, 1, 1, 1, 0, 3); tick();
    instr(4, 5, 1, 1, 1, 0, 3); tick();
    instr(3, 3, 1, 1, 1, 0, 4); tick(); #1;
    chk("young_fwd_a", forward_EXE_A, 1);
    chk("young_fwd_b", forward_EXE_B, 1);
    instr(1, 2, 1, 1, 1, 0, 0); tick();
    instr(0, 0, 1, 1, 1, 0, 5); tick(); #1;
    chk("zero_fwd_a", forward_EXE_A, 0);
    chk("zero_fwd_b", forward_EXE_B, 0);
    drain();

    // load-use coinciding with flush
    instr(1, 0, 1, 0, 1, 1, 8); tick();
    instr(8, 8, 1, 1, 1, 0, 9); flush = 1'b1; #1;
    chk("flush_stall", stall, 0);
    tick(); #1;
    chk("flush_cnt", stall_cnt, 1);
    chk("flush_fwd_a", forward_EXE_A, 0);
    flush = 1'b0;
    drain();

    // freeze for 3 cycles in the middle of a stall
    instr(1, 0, 1, 0, 1, 1, 8); tick();
    instr(8, 8, 1, 1, 1, 0, 9); en = 1'b0;
    repeat (3) tick();
    #1;
    chk("frz_stall", stall, 1);
    chk("frz_cnt", stall_cnt, 1);
    en = 1'b1;
    tick(); #1;
    chk("frz_cnt_after", stall_cnt, 2);
    tick(); #1;
    chk("frz_fwd_a", forward_EXE_A, 2);
    drain();

    // reset in the middle of a forwarding sequence
    instr(1, 2, 1, 1, 1, 0, 3); tick();
    instr(3, 5, 1, 1, 1, 0, 4); tick();
    rst_n = 1'b0; #1;
    chk("mrst_fwd_a", forward_EXE_A, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_cnt", stall_cnt, 0);
    instr(3, 3, 1, 1, 1, 0, 4); tick();
    rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_fwd_a", forward_EXE_A, 0);
    chk("post_rst_fwd_b", forward_EXE_B, 0);
    drain();

    // 2^CNT_W + 5 stalls: counter must saturate
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      instr(1, 0, 1, 0, 1, 1, 8); tick();
      instr(8, 2, 1, 1, 1, 0, 9); tick();
      tick();
    end
    #1;
    chk("sat_cnt", stall_cnt, CNTMAX);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
